bcd_arb_ctrl: RTL and testbench
===============================

BCD_ARB_CTRL -- requirements
Module: bcd_arb_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 24, meaning the maximum number of WAIT cycles allowed for conv_done before the request is aborted.
REQ-002 The block SHALL have port clk  input  1  system clock, all logic on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; rst is synchronous and active-high, clock is clk.
REQ-004 The block SHALL have port req  input  2  level request per requester (bit 0 humidity, bit 1 temperature).
REQ-005 The block SHALL have port bin0  input  8  binary value of requester 0, held stable while req[0]=1.
REQ-006 The block SHALL have port bin1  input  8  binary value of requester 1, held stable while req[1]=1.
REQ-007 The block SHALL have port ack  output  2  one-cycle completion pulse per requester.
REQ-008 The block SHALL have port bcd_out  output  8  two-digit packed BCD result, valid only while ack is nonzero.
REQ-009 The block SHALL have port err  output  1  error qualifier, valid only while ack is nonzero.
REQ-010 The block SHALL have port gnt_id  output  1  index of the currently granted requester.
REQ-011 The block SHALL have port conv_start  output  1  one-cycle start pulse to the shared converter.
REQ-012 The block SHALL have port conv_bin  output  8  operand to the converter, registered and held from START until the next grant.
REQ-013 The block SHALL have port conv_done  input  1  one-cycle completion pulse from the converter.
REQ-014 The block SHALL have port conv_bcd  input  8  converter result, valid while conv_done=1.

Function
REQ-015 The block SHALL implement the states IDLE, START, WAIT and RESP as registered state.
REQ-016 In IDLE with any req bit set, the block SHALL grant one requester at the clock edge: the single requester if only one is set; if both are set, the one not granted last (round robin).
REQ-017 The last-grant register SHALL reset to 1, so that requester 0 wins the first tie.
REQ-018 The grant edge SHALL latch gnt_id and the selected bin into conv_bin.
REQ-019 If the selected bin is 0..99, the block SHALL go to START; if the selected bin is above 99, it SHALL go directly to RESP with the range-error flag set.
REQ-020 In START, conv_start SHALL be 1 for exactly one cycle, and the next state SHALL be WAIT with the timeout counter cleared.
REQ-021 In WAIT, when conv_done=1 the block SHALL capture conv_bcd and go to RESP.
REQ-022 In WAIT, when the timeout counter reaches TIMEOUT-1 without conv_done, the block SHALL go to RESP with the timeout flag set; otherwise the counter SHALL increment by one.
REQ-023 In RESP, ack[gnt_id] SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-024 In RESP with a normal completion, bcd_out SHALL equal the captured conv_bcd and err SHALL be 0.
REQ-025 In RESP with a range error, bcd_out SHALL be 8'h99 (saturated) and err SHALL be 1.
REQ-026 In RESP with a timeout, bcd_out SHALL be 8'h00 and err SHALL be 1.
REQ-027 Outside RESP, ack SHALL be 2'b00 and bcd_out and err SHALL be 0.
REQ-028 Latency SHALL be: grant edge, then START, then conv_done in cycle n, then ack in cycle n+1; for the range-error path, ack SHALL occur in the cycle after the grant edge.
REQ-029 A requester SHALL drop req in the cycle after ack; a req still high in IDLE after RESP SHALL be treated as a new request, subject to round robin.
REQ-030 conv_done asserted in any state other than WAIT SHALL be ignored with no state change.
REQ-031 A req change while a conversion is in progress SHALL NOT affect the active transaction.
REQ-032 The bin value SHALL be sampled only at the grant edge.

Reset
REQ-033 While rst=1, the block SHALL go to IDLE with ack=0, bcd_out=0, err=0, gnt_id=0, conv_start=0, conv_bin=0, timeout counter 0 and last-grant register 1.
REQ-034 rst asserted mid-transaction (START, WAIT or RESP) SHALL abort the transaction with no ack.
REQ-035 A conv_done pulse arriving after an aborting rst SHALL be ignored.

Verification
REQ-036 The bench SHALL cover: rst, then req=2'b01, bin0=42, converter model pulsing conv_done 17 cycles after conv_start with conv_bcd=8'h42 -> ack=2'b01 for one cycle, bcd_out=8'h42, err=0.
REQ-037 The bench SHALL cover: req=2'b11 held from reset, bin0=7, bin1=85 -> ack[0] with 8'h07 first, then ack[1] with 8'h85, exactly one conv_start per transaction; the next tie SHALL be granted to requester 0.
REQ-038 The bench SHALL cover: req=2'b10, bin1=200 -> no conv_start, ack=2'b10 in the cycle after the grant edge, bcd_out=8'h99, err=1.
REQ-039 The bench SHALL cover: boundaries bin0=99 -> 8'h99, err=0; bin0=0 -> 8'h00, err=0.
REQ-040 The bench SHALL cover: converter never pulses conv_done, TIMEOUT=24 -> ack after 24 WAIT cycles, bcd_out=8'h00, err=1, then state IDLE.
REQ-041 The bench SHALL cover: rst pulsed during WAIT, followed by a late conv_done -> no ack, all outputs 0, next req served normally.

Source files
------------

// File: rtl/bcd_arb_ctrl.sv
// Two-requester round-robin arbiter in front of a shared binary-to-BCD converter.
// Out-of-range operands are answered directly; a stalled converter is timed out.
module bcd_arb_ctrl #(
    parameter int TIMEOUT = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] bin0,
    input  logic [7:0] bin1,
    output logic [1:0] ack,
    output logic [7:0] bcd_out,
    output logic       err,
    output logic       gnt_id,
    output logic       conv_start,
    output logic [7:0] conv_bin,
    input  logic       conv_done,
    input  logic [7:0] conv_bcd
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             gnt_id_q, gnt_id_d;
    logic             last_q, last_d;
    logic [7:0]       conv_bin_q, conv_bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       res_q, res_d;
    logic             err_q, err_d;
    logic             sel;
    logic [7:0]       sel_bin;
    logic             in_resp;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        sel = ~last_q;
        if (req == 2'b01) begin
            sel = 1'b0;
        end else if (req == 2'b10) begin
            sel = 1'b1;
        end
        sel_bin = sel ? bin1 : bin0;
    end

    // NOTE: every next-state signal defaults to its held value first, so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        last_d     = last_q;
        conv_bin_d = conv_bin_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    gnt_id_d   = sel;
                    last_d     = sel;
                    conv_bin_d = sel_bin;
                    if (sel_bin > 8'd99) begin
                        res_d   = 8'h99;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (conv_done) begin
                    res_d   = conv_bcd;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_d   = 8'h00;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_id_q   <= 1'b0;
            last_q     <= 1'b1;
            conv_bin_q <= 8'h00;
            cnt_q      <= '0;
            res_q      <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            last_q     <= last_d;
            conv_bin_q <= conv_bin_d;
            cnt_q      <= cnt_d;
            res_q      <= res_d;
            err_q      <= err_d;
        end
    end

    // Response outputs are gated by RESP so they read zero in every other state.
    assign in_resp    = (state_q == S_RESP);
    assign ack        = in_resp ? (gnt_id_q ? 2'b10 : 2'b01) : 2'b00;
    assign bcd_out    = in_resp ? res_q : 8'h00;
    assign err        = in_resp & err_q;
    assign conv_start = (state_q == S_START);
    assign gnt_id     = gnt_id_q;
    assign conv_bin   = conv_bin_q;

endmodule

// File: tb/tb_bcd_arb_ctrl.sv
// Directed bench for bcd_arb_ctrl with a delayed-response converter model.
module tb_bcd_arb_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [7:0] bin0;
    logic [7:0] bin1;
    logic [1:0] ack;
    logic [7:0] bcd_out;
    logic       err;
    logic       gnt_id;
    logic       conv_start;
    logic [7:0] conv_bin;
    logic       conv_done;
    logic [7:0] conv_bcd;

    int tests;
    int fails;
    int start_cnt;
    int done_cnt;
    int cd;
    int conv_delay;
    bit model_en;
    logic [7:0] conv_result;

    bcd_arb_ctrl #(.TIMEOUT(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .bin0       (bin0),
        .bin1       (bin1),
        .ack        (ack),
        .bcd_out    (bcd_out),
        .err        (err),
        .gnt_id     (gnt_id),
        .conv_start (conv_start),
        .conv_bin   (conv_bin),
        .conv_done  (conv_done),
        .conv_bcd   (conv_bcd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Converter model: pulses conv_done conv_delay cycles after the conv_start cycle.
    initial begin
        conv_done = 1'b0;
        conv_bcd  = 8'h00;
        cd        = -1;
        start_cnt = 0;
        done_cnt  = 0;
        forever begin
            @(negedge clk);
            conv_done = 1'b0;
            conv_bcd  = 8'h00;
            if (cd > 0) cd--;
            if (cd == 0) begin
                conv_done = 1'b1;
                conv_bcd  = conv_result;
                done_cnt++;
                cd = -1;
            end
            if (conv_start) begin
                start_cnt++;
                if (model_en) cd = conv_delay;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ack == 2'b00 && n < max);
        check("ack_present", 32'(ack != 2'b00), 1);
    endtask

    int n;
    int s0;
    int d0;
    bit seen;

    initial begin
        tests       = 0;
        fails       = 0;
        rst         = 1'b1;
        req         = 2'b00;
        bin0        = 8'd0;
        bin1        = 8'd0;
        model_en    = 1'b1;
        conv_delay  = 17;
        conv_result = 8'h00;
        tick();
        tick();

        check("rst_ack", 32'(ack), 0);
        check("rst_bcd", 32'(bcd_out), 0);
        check("rst_err", 32'(err), 0);
        check("rst_gnt", 32'(gnt_id), 0);
        check("rst_start", 32'(conv_start), 0);
        check("rst_bin", 32'(conv_bin), 0);

        // Single request, normal conversion
        rst = 1'b0; req = 2'b01; bin0 = 8'd42; conv_result = 8'h42;
        tick();
        check("t1_start", 32'(conv_start), 1);
        check("t1_gnt", 32'(gnt_id), 0);
        check("t1_bin", 32'(conv_bin), 42);
        wait_ack(40, n);
        check("t1_lat", n, 18);
        check("t1_ack", 32'(ack), 32'h1);
        check("t1_bcd", 32'(bcd_out), 32'h42);
        check("t1_err", 32'(err), 0);
        req = 2'b00;
        tick();
        check("t1_ack_once", 32'(ack), 0);

        // Tie held from reset, round robin
        rst = 1'b1; req = 2'b11; bin0 = 8'd7; bin1 = 8'd85; conv_result = 8'h07;
        tick();
        rst = 1'b0;
        s0 = start_cnt;
        tick();
        check("t2_gnt_a", 32'(gnt_id), 0);
        wait_ack(40, n);
        check("t2_ack_a", 32'(ack), 32'h1);
        check("t2_bcd_a", 32'(bcd_out), 32'h07);
        conv_result = 8'h85;
        tick();
        tick();
        check("t2_gnt_b", 32'(gnt_id), 1);
        check("t2_bin_b", 32'(conv_bin), 85);
        wait_ack(40, n);
        check("t2_ack_b", 32'(ack), 32'h2);
        check("t2_bcd_b", 32'(bcd_out), 32'h85);
        check("t2_starts2", start_cnt - s0, 2);
        tick();
        tick();
        check("t2_gnt_c", 32'(gnt_id), 0);
        check("t2_start_c", 32'(conv_start), 1);
        req = 2'b00; conv_result = 8'h07;
        wait_ack(40, n);
        check("t2_ack_c", 32'(ack), 32'h1);
        check("t2_starts3", start_cnt - s0, 3);
        tick();

        // Range error: direct response in the cycle after the grant edge
        req = 2'b10; bin1 = 8'd200;
        s0 = start_cnt;
        tick();
        check("t3_ack", 32'(ack), 32'h2);
        check("t3_bcd", 32'(bcd_out), 32'h99);
        check("t3_err", 32'(err), 1);
        check("t3_nostart", 32'(conv_start), 0);
        check("t3_bin", 32'(conv_bin), 200);
        req = 2'b00;
        tick();
        check("t3_ack_off", 32'(ack), 0);
        check("t3_err_off", 32'(err), 0);
        check("t3_starts", start_cnt - s0, 0);

        // Range boundaries
        req = 2'b01; bin0 = 8'd99; conv_result = 8'h99;
        tick();
        wait_ack(40, n);
        check("t4_99_bcd", 32'(bcd_out), 32'h99);
        check("t4_99_err", 32'(err), 0);
        req = 2'b00;
        tick();
        req = 2'b01; bin0 = 8'd0; conv_result = 8'h00;
        tick();
        wait_ack(40, n);
        check("t4_0_ack", 32'(ack), 32'h1);
        check("t4_0_bcd", 32'(bcd_out), 32'h00);
        check("t4_0_err", 32'(err), 0);
        req = 2'b00;
        tick();
        req = 2'b01; bin0 = 8'd100;
        tick();
        check("t4_100_ack", 32'(ack), 32'h1);
        check("t4_100_bcd", 32'(bcd_out), 32'h99);
        check("t4_100_err", 32'(err), 1);
        req = 2'b00;
        tick();

        // Converter never answers: timeout after 24 WAIT cycles
        model_en = 1'b0;
        req = 2'b01; bin0 = 8'd50;
        tick();
        req = 2'b00;
        wait_ack(40, n);
        check("t5_lat", n, 25);
        check("t5_ack", 32'(ack), 32'h1);
        check("t5_bcd", 32'(bcd_out), 32'h00);
        check("t5_err", 32'(err), 1);
        tick();
        check("t5_idle_ack", 32'(ack), 0);
        tick();
        check("t5_idle_start", 32'(conv_start), 0);
        model_en = 1'b1;

        // Reset during WAIT, then a late conv_done
        req = 2'b01; bin0 = 8'd33; conv_result = 8'h33;
        tick();
        req = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        check("t6_ack", 32'(ack), 0);
        check("t6_bcd", 32'(bcd_out), 0);
        check("t6_err", 32'(err), 0);
        check("t6_gnt", 32'(gnt_id), 0);
        check("t6_start", 32'(conv_start), 0);
        check("t6_bin", 32'(conv_bin), 0);
        rst = 1'b0;
        d0 = done_cnt;
        s0 = start_cnt;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (ack != 2'b00) seen = 1'b1;
        end
        check("t6_late_done", done_cnt - d0, 1);
        check("t6_no_ack", 32'(seen), 0);
        check("t6_no_start", start_cnt - s0, 0);
        req = 2'b10; bin1 = 8'd12; conv_result = 8'h12;
        tick();
        check("t6_gnt", 32'(gnt_id), 1);
        check("t6_start2", 32'(conv_start), 1);
        wait_ack(40, n);
        check("t6_lat", n, 18);
        check("t6_ack2", 32'(ack), 32'h2);
        check("t6_bcd2", 32'(bcd_out), 32'h12);
        check("t6_err2", 32'(err), 0);
        req = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
